vec_op_sequencer: RTL and testbench
===================================

// Module: vec_op_sequencer
// PURPOSE
//  Sequences one element-wise vector operation (add/mul) on the coprocessor datapath behind the Wishbone slave.
//  Takes a command (op, two source bases, destination base, length) from the Wishbone register block.
//  Streams element reads from the vector register file into the shared ALU lane.
//  Writes the results back and pulses done, which firmware reports on the checkbits GPIOs.
// PARAMETERS
//  DATA_W   16  element width (RF data, ALU operands/result)
//  ADDR_W   5   vector RF element address width; all addresses wrap mod 2^ADDR_W
//  LEN_W    6   command length width; 0..2^LEN_W-1 elements
//  ALU_LAT  2   fixed ALU latency, alu_valid -> alu_result (>=1)
// PORTS
//  wb_clk_i      in   1       clock
//  wb_rst_i      in   1       reset, asynchronous, active-high
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_op        in   2       00 add, 01 mul, 1x reserved (executed as add)
//  cmd_src_a     in   ADDR_W  base address of operand vector A
//  cmd_src_b     in   ADDR_W  base address of operand vector B
//  cmd_dst       in   ADDR_W  base address of result vector
//  cmd_len       in   LEN_W   element count
//  abort         in   1       cancel the running command
//  rf_rd_en      out  1       RF read strobe; data returns next cycle
//  rf_rd_addr_a  out  ADDR_W  A read address
//  rf_rd_addr_b  out  ADDR_W  B read address
//  rf_rd_data_a  in   DATA_W  A read data (1-cycle latency)
//  rf_rd_data_b  in   DATA_W  B read data (1-cycle latency)
//  alu_valid     out  1       operands valid this cycle
//  alu_op        out  2       latched cmd_op
//  alu_a, alu_b  out  DATA_W  operands = rf_rd_data_a/b passed through
//  alu_result    in   DATA_W  result, valid ALU_LAT cycles after alu_valid
//  rf_wr_en      out  1       RF write strobe
//  rf_wr_addr    out  ADDR_W  write address
//  rf_wr_data    out  DATA_W  = alu_result (combinational)
//  busy          out  1       state != IDLE
//  done          out  1       1-cycle completion pulse
// BEHAVIOUR
//  - Reset (async): state IDLE; counters/tag pipe cleared; rf_rd_en, alu_valid, rf_wr_en, busy, done = 0.
//    cmd_ready = (state==IDLE); cmd_valid is ignored while wb_rst_i is high.
//  - FSM IDLE->ISSUE on accept (len>0); IDLE->DONE on accept (len==0); ISSUE->DRAIN after last read.
//    DRAIN->DONE after last write; DONE->IDLE (always 1 cycle).
//  - Accept latches op, bases and len. Cycle 0 = accept cycle.
//  - Element i (0..len-1):
//    rf_rd_en at cycle 1+i, addrs src_a+i / src_b+i.
//    alu_valid at 2+i.
//    rf_wr_en at 2+i+ALU_LAT, addr dst+i.
//    One element per cycle, no bubbles.
//  - The dst address/valid travel down a (1+ALU_LAT)-deep tag shift register; the ALU returns no tag.
//  - done at cycle len+2+ALU_LAT, or cycle 1 for len==0. cmd_ready is high again at done+1.
//  - Address arithmetic: ADDR_W-bit modular addition; 31+1 -> 0 with ADDR_W=5.
//  - No hazard checking. The RF contract is read-before-write on a same-address collision in one cycle.
//    Overlapping src/dst with dst-src > ALU_LAT is undefined; dst==src (in-place) is legal.
//  - abort is honoured in ISSUE/DRAIN at cycle t:
//    from t+1, no rf_rd_en, alu_valid or rf_wr_en (tag pipe flushed); state IDLE at t+1; no done pulse.
//    abort in IDLE/DONE has no effect.
//  - Reset mid-operation: same as abort, asynchronously; outputs low immediately.
//  - Arithmetic belongs to the ALU; the sequencer passes data unmodified and never stalls.
// TESTING
//  1 mul, len=4, A@0={1,2,3,4}, B@8={5,6,7,8}, dst=16
//    -> RF[16..19]={5,12,21,32}; rf_wr_en cycles 4..7; done cycle 8 only.
//  2 add, len=0 -> done at cycle 1; rf_rd_en/alu_valid/rf_wr_en never asserted; busy high cycles 1 only.
//  3 add, len=4, src_a=30, src_b=2, dst=29 -> read addrs 30,31,0,1; write addrs 29,30,31,0.
//  4 add, len=8, abort at cycle 3 -> writes never occur; busy=0 and cmd_ready=1 at cycle 4; done never.
//  5 two commands back-to-back, cmd_valid held -> second accepted at first done+1; results correct and non-interleaved.
//  6 wb_rst_i pulsed mid-DRAIN of a len=6 mul -> all strobes drop async; no further writes; next command executes normally.

Source files
------------

// File: rtl/vec_op_sequencer.sv
// Element-wise vector add/mul sequencer: streams operand reads from the vector RF into the
// shared ALU lane and writes results back, carrying the write address in a tag pipe.
module vec_op_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int LEN_W   = 6,
    parameter int ALU_LAT = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic              alu_valid,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy,
    output logic              done
);

    localparam int TAG_D = ALU_LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;

    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  src_a_q, src_b_q, dst_q;
    logic [LEN_W-1:0]   len_q;

    logic               alu_vld_p0;
    logic [TAG_D-1:0]   tag_vld_q;
    logic [ADDR_W-1:0]  tag_addr_q [TAG_D];

    logic               accept;
    logic               abort_hit;
    logic               last_rd;
    logic               last_wr;
    logic [ADDR_W-1:0]  wr_addr_p0;

    assign accept    = cmd_valid && cmd_ready;
    assign abort_hit = abort && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign last_rd   = (rd_cnt_q == (len_q - LEN_W'(1)));
    // Final write: the oldest tag is live and nothing younger is still in flight.
    assign last_wr   = tag_vld_q[ALU_LAT] && (tag_vld_q[ALU_LAT-1:0] == '0);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_cnt_d = '0;
                    state_d  = (cmd_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_cnt_d = rd_cnt_q + LEN_W'(1);
                if (last_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_wr) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
        end
    end

    // Command latch: pure data, only meaningful once the FSM leaves IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (accept && !wb_rst_i) begin
            op_q    <= cmd_op;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
            len_q   <= cmd_len;
        end
    end

    // Stage p0: RF read issue; the write address enters the tag pipe alongside the read.
    assign rf_rd_en     = (state_q == S_ISSUE);
    assign rf_rd_addr_a = src_a_q + ADDR_W'(rd_cnt_q);
    assign rf_rd_addr_b = src_b_q + ADDR_W'(rd_cnt_q);
    assign wr_addr_p0   = dst_q + ADDR_W'(rd_cnt_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            alu_vld_p0 <= 1'b0;
            tag_vld_q  <= '0;
            for (int k = 0; k < TAG_D; k++) begin
                tag_addr_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            if (abort_hit) begin
                alu_vld_p0 <= 1'b0;
                tag_vld_q  <= '0;
            end else begin
                alu_vld_p0 <= rf_rd_en;
                tag_vld_q  <= {tag_vld_q[TAG_D-2:0], rf_rd_en};
            end
            tag_addr_q[0] <= wr_addr_p0;
            for (int k = 1; k < TAG_D; k++) begin
                tag_addr_q[k] <= tag_addr_q[k-1];
            end
        end
    end

    // Stage p1: RF data returns and is handed to the ALU untouched.
    assign alu_valid = alu_vld_p0;
    assign alu_op    = op_q;
    assign alu_a     = rf_rd_data_a;
    assign alu_b     = rf_rd_data_b;

    // Stage p1+ALU_LAT: result meets its tag and is written back.
    assign rf_wr_en   = tag_vld_q[ALU_LAT];
    assign rf_wr_addr = tag_addr_q[ALU_LAT];
    assign rf_wr_data = alu_result;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cmd_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed bench for vec_op_sequencer with a behavioural vector RF (1-cycle read) and a
// 2-cycle ALU; expected timings and results are hand-computed constants.
module tb_vec_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [5:0]  cmd_len;
    logic        abort;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_rd_data_a, rf_rd_data_b;
    logic        alu_valid;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        busy, done;

    always #5 clk = ~clk;

    vec_op_sequencer #(.DATA_W(16), .ADDR_W(5), .LEN_W(6), .ALU_LAT(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .abort(abort),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .busy(busy), .done(done)
    );

    // Vector RF model: registered read, write port shared with a bench preload port.
    logic [15:0] rf [32];
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [15:0] tb_wd;

    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd_data_a <= rf[rf_rd_addr_a];
            rf_rd_data_b <= rf[rf_rd_addr_b];
        end
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end

    // ALU model, latency 2; op 1x behaves as add.
    logic [15:0] alu_s1, alu_s2;
    always @(posedge clk) begin
        alu_s1 <= (alu_op == 2'b01) ? alu_a * alu_b : alu_a + alu_b;
        alu_s2 <= alu_s1;
    end
    assign alu_result = alu_s2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc;
    logic [31:0] rd_mask, alu_mask, wr_mask, done_mask, busy_mask, ready_mask, acc_mask;
    logic [4:0]  rda_q[$], rdb_q[$], wr_q[$];
    logic [15:0] alua_q[$];
    logic [1:0]  last_op;

    int e3_rda[4] = '{30, 31, 0, 1};
    int e3_rdb[4] = '{2, 3, 4, 5};
    int e3_wr[4]  = '{29, 30, 31, 0};
    int e3_res[4] = '{101, 202, 303, 404};
    int e5_wr[4]  = '{24, 25, 26, 27};
    int e5_res[4] = '{6, 8, 21, 32};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_load(input logic [4:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic clear_logs();
        rd_mask = '0; alu_mask = '0; wr_mask = '0; done_mask = '0;
        busy_mask = '0; ready_mask = '0; acc_mask = '0; n_acc = 0;
        rda_q.delete(); rdb_q.delete(); wr_q.delete(); alua_q.delete();
        last_op = 2'b00;
    endtask

    task automatic sample(input int c);
        if (rf_rd_en) begin
            rd_mask[c] = 1'b1;
            rda_q.push_back(rf_rd_addr_a);
            rdb_q.push_back(rf_rd_addr_b);
        end
        if (alu_valid) begin
            alu_mask[c] = 1'b1;
            alua_q.push_back(alu_a);
            last_op = alu_op;
        end
        if (rf_wr_en) begin
            wr_mask[c] = 1'b1;
            wr_q.push_back(rf_wr_addr);
        end
        if (done)      done_mask[c]  = 1'b1;
        if (busy)      busy_mask[c]  = 1'b1;
        if (cmd_ready) ready_mask[c] = 1'b1;
        if (cmd_valid && cmd_ready) begin
            acc_mask[c] = 1'b1;
            n_acc++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [5:0] len);
        cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_len = len;
        cmd_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; tb_we = 1'b0;
        cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_len = '0;
        tb_wa = '0; tb_wd = '0;
        clear_logs();

        // Reset state, with a command offered while reset is held.
        tick();
        issue(2'b00, 5'd0, 5'd0, 5'd0, 6'd3);
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst rd_en", rf_rd_en, 0);
        check("rst alu_valid", alu_valid, 0);
        check("rst wr_en", rf_wr_en, 0);
        check("rst cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("post-rst busy", busy, 0);

        // 1: mul len 4
        for (int i = 0; i < 4; i++) begin
            rf_load(5'(i), 16'(i + 1));
            rf_load(5'(8 + i), 16'(5 + i));
        end
        clear_logs();
        issue(2'b01, 5'd0, 5'd8, 5'd16, 6'd4);
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        check("t1 rd cycles", rd_mask, 32'h1E);
        check("t1 alu cycles", alu_mask, 32'h3C);
        check("t1 wr cycles", wr_mask, 32'hF0);
        check("t1 done cycles", done_mask, 32'h100);
        check("t1 busy cycles", busy_mask, 32'h1FE);
        check("t1 ready cycles", ready_mask, 32'h1E01);
        check("t1 alu_op", last_op, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1 alu_a%0d", i), alua_q[i], i + 1);
            check($sformatf("t1 wr addr%0d", i), wr_q[i], 16 + i);
        end
        check("t1 rf16", rf[16], 5);
        check("t1 rf17", rf[17], 12);
        check("t1 rf18", rf[18], 21);
        check("t1 rf19", rf[19], 32);

        // 2: add len 0
        clear_logs();
        issue(2'b00, 5'd0, 5'd8, 5'd16, 6'd0);
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        check("t2 done cycles", done_mask, 32'h2);
        check("t2 busy cycles", busy_mask, 32'h2);
        check("t2 ready cycles", ready_mask, 32'h1D);
        check("t2 strobes", rd_mask | alu_mask | wr_mask, 32'h0);

        // 3: add len 4 with address wrap
        rf_load(5'd30, 16'd100); rf_load(5'd31, 16'd200);
        rf_load(5'd0, 16'd300);  rf_load(5'd1, 16'd400);
        for (int i = 0; i < 4; i++) rf_load(5'(2 + i), 16'(i + 1));
        clear_logs();
        issue(2'b00, 5'd30, 5'd2, 5'd29, 6'd4);
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        check("t3 n_rd", rda_q.size(), 4);
        check("t3 n_wr", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3 rd_a%0d", i), rda_q[i], e3_rda[i]);
            check($sformatf("t3 rd_b%0d", i), rdb_q[i], e3_rdb[i]);
            check($sformatf("t3 wr%0d", i), wr_q[i], e3_wr[i]);
            check($sformatf("t3 res%0d", i), rf[e3_wr[i]], e3_res[i]);
        end
        check("t3 done cycles", done_mask, 32'h100);

        // 4: add len 8, abort at cycle 3
        rf_load(5'd20, 16'hDEAD); rf_load(5'd27, 16'hDEAD);
        clear_logs();
        issue(2'b00, 5'd0, 5'd8, 5'd20, 6'd8);
        for (int c = 0; c <= 14; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            abort = (c == 3);
            sample(c);
            tick();
        end
        abort = 1'b0;
        check("t4 rd cycles", rd_mask, 32'hE);
        check("t4 alu cycles", alu_mask, 32'hC);
        check("t4 wr cycles", wr_mask, 32'h0);
        check("t4 done cycles", done_mask, 32'h0);
        check("t4 busy cycles", busy_mask, 32'hE);
        check("t4 ready cycles", ready_mask, 32'h7FF1);
        check("t4 rf20", rf[20], 16'hDEAD);
        check("t4 rf27", rf[27], 16'hDEAD);

        // 5: back-to-back commands with cmd_valid held
        for (int i = 0; i < 4; i++) begin
            rf_load(5'(i), 16'(i + 1));
            rf_load(5'(8 + i), 16'(5 + i));
        end
        clear_logs();
        issue(2'b00, 5'd0, 5'd8, 5'd24, 6'd2);
        for (int c = 0; c <= 16; c++) begin
            if (n_acc == 1) begin
                cmd_op = 2'b01; cmd_src_a = 5'd2; cmd_src_b = 5'd10; cmd_dst = 5'd26;
            end
            if (n_acc >= 2) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        cmd_valid = 1'b0;
        check("t5 accept cycles", acc_mask, 32'h81);
        check("t5 wr cycles", wr_mask, 32'h1830);
        check("t5 done cycles", done_mask, 32'h2040);
        check("t5 busy cycles", busy_mask, 32'h3F7E);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5 wr%0d", i), wr_q[i], e5_wr[i]);
            check($sformatf("t5 res%0d", i), rf[e5_wr[i]], e5_res[i]);
        end

        // 6: reset pulsed mid-DRAIN of a mul len 6
        for (int i = 0; i < 6; i++) begin
            rf_load(5'(i), 16'(i + 1));
            rf_load(5'(8 + i), 16'd2);
            rf_load(5'(16 + i), 16'hBEEF);
        end
        clear_logs();
        issue(2'b01, 5'd0, 5'd8, 5'd16, 6'd6);
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        sample(8);
        check("t6 wr before rst", rf_wr_en, 1);
        #2 rst = 1'b1;
        #1;
        check("t6 async wr_en", rf_wr_en, 0);
        check("t6 async busy", busy, 0);
        check("t6 async rd_en", rf_rd_en, 0);
        check("t6 async alu_valid", alu_valid, 0);
        tick();
        #2 rst = 1'b0;
        tick();
        for (int c = 10; c <= 13; c++) begin
            sample(c);
            tick();
        end
        check("t6 wr cycles", wr_mask, 32'h1F0);
        check("t6 done cycles", done_mask, 32'h0);
        check("t6 rf16", rf[16], 2);
        check("t6 rf19", rf[19], 8);
        check("t6 rf20", rf[20], 16'hBEEF);
        check("t6 rf21", rf[21], 16'hBEEF);

        clear_logs();
        issue(2'b00, 5'd0, 5'd8, 5'd28, 6'd2);
        for (int c = 0; c <= 9; c++) begin
            if (c == 1) cmd_valid = 1'b0;
            sample(c);
            tick();
        end
        check("t6 next done", done_mask, 32'h40);
        check("t6 next rf28", rf[28], 3);
        check("t6 next rf29", rf[29], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
